// File: rtl/am_lane_inserter.sv
// Alignment-marker inserter: forwards lane beats through one output register and
// inserts an AM beat (lane index + per-lane BIP8) after every AM_PERIOD accepted data beats.
module am_lane_inserter #(
  parameter int unsigned                DATA_WIDTH   = 64,
  parameter int unsigned                NUMBER_LANES = 8,
  parameter int unsigned                AM_PERIOD    = 16,
  parameter logic [DATA_WIDTH-1:0]      AM_BASE      = 64'h9A4A_26B6_65B5_D900
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_valid,
  output logic                               o_ready,
  input  logic [NUMBER_LANES*DATA_WIDTH-1:0] i_data,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic [NUMBER_LANES*DATA_WIDTH-1:0] o_data,
  output logic                               o_am
);

  localparam int unsigned CNT_W = (AM_PERIOD > 2) ? $clog2(AM_PERIOD) : 1;

  typedef enum logic {ST_DATA, ST_AM} state_t;

  state_t                               r_state;
  logic                                 r_valid;
  logic                                 r_am;
  logic [NUMBER_LANES*DATA_WIDTH-1:0]   r_data;
  logic [CNT_W-1:0]                     r_cnt;
  logic [NUMBER_LANES-1:0][7:0]         r_bip;

  logic                                 w_load;
  logic [NUMBER_LANES-1:0][7:0]         w_bip_acc;
  logic [NUMBER_LANES*DATA_WIDTH-1:0]   w_am_data;

  function automatic logic [7:0] bytexor(input logic [DATA_WIDTH-1:0] w);
    logic [7:0] x;
    x = '0;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++) begin
      x = x ^ w[b*8 +: 8];
    end
    return x;
  endfunction

  assign w_load  = !r_valid || i_ready;
  assign o_ready = (r_state == ST_DATA) && w_load;
  assign o_valid = r_valid;
  assign o_am    = r_am;
  assign o_data  = r_data;

  always_comb begin
    w_bip_acc = '0;
    w_am_data = '0;
    for (int unsigned l = 0; l < NUMBER_LANES; l++) begin
      w_bip_acc[l]                     = r_bip[l] ^ bytexor(i_data[l*DATA_WIDTH +: DATA_WIDTH]);
      w_am_data[l*DATA_WIDTH +: DATA_WIDTH] = {AM_BASE[DATA_WIDTH-1:16], 8'(l), r_bip[l]};
    end
  end

  // BIP accumulates on the same edge a data beat is accepted, so the last beat
  // before the marker is included in the marker's BIP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_AM;
      r_valid <= 1'b0;
      r_am    <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_bip   <= '0;
    end else if (w_load) begin
      case (r_state)
        ST_DATA: begin
          if (i_valid) begin
            r_data  <= i_data;
            r_am    <= 1'b0;
            r_valid <= 1'b1;
            r_bip   <= w_bip_acc;
            if (r_cnt == CNT_W'(AM_PERIOD - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_AM;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end else begin
            r_valid <= 1'b0;
          end
        end
        ST_AM: begin
          r_data  <= w_am_data;
          r_am    <= 1'b1;
          r_valid <= 1'b1;
          r_bip   <= '0;
          r_state <= ST_DATA;
        end
        default: r_state <= ST_AM;
      endcase
    end
  end

endmodule

// File: tb/tb_am_lane_inserter.sv
// Scoreboard bench for am_lane_inserter: a reference model queues expected beats on each
// accepted input; a monitor checks each presented output beat, hold stability and latency.
module tb_am_lane_inserter;
  localparam int DW = 64;
  localparam int NL = 8;
  localparam int AP = 16;
  localparam int W  = DW * NL;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_valid = 1'b0;
  logic         i_ready = 1'b0;
  logic [W-1:0] i_data = '0;
  logic         o_ready;
  logic         o_valid;
  logic         o_am;
  logic [W-1:0] o_data;

  am_lane_inserter #(
    .DATA_WIDTH  (DW),
    .NUMBER_LANES(NL),
    .AM_PERIOD   (AP),
    .AM_BASE     (64'h9A4A_26B6_65B5_D900)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_data (i_data),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_data (o_data),
    .o_am   (o_am)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         am;
    logic [W-1:0] data;
    int           cyc;
  } beat_t;

  int           checks = 0;
  int           errors = 0;
  beat_t        exp_q[$];
  logic [W-1:0] per_q[$];
  int           m_cnt = 0;
  int           cyc = 0;
  bit           shown = 0;
  logic [W-1:0] held_d;
  logic         held_am;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // Marker from the data beats of the finished period: each lane's BIP is the XOR of
  // every byte that lane carried during the period.
  function automatic logic [W-1:0] am_word();
    logic [W-1:0]  d;
    logic [7:0]    b;
    logic [63:0]   base;
    base = 64'h9A4A_26B6_65B5_D900;
    d = '0;
    for (int l = 0; l < NL; l++) begin
      b = 8'h00;
      foreach (per_q[k])
        for (int by = 0; by < DW / 8; by++)
          b = b ^ per_q[k][l*DW + by*8 +: 8];
      d[l*DW +: DW] = {base[63:16], 8'(l), b};
    end
    return d;
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      per_q.delete();
      m_cnt = 0;
      shown = 0;
      exp_q.push_back('{am: 1'b1, data: am_word(), cyc: -1});
    end else begin
      if (o_valid) begin
        if (!shown) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat act=o_valid=1 am=%0b exp=no beat pending", o_am);
          end else begin
            chk("beat_am", W'(o_am), W'(exp_q[0].am));
            chk("beat_data", o_data, exp_q[0].data);
            if (!exp_q[0].am) chk("latency", W'(cyc), W'(exp_q[0].cyc + 1));
          end
          shown   = 1;
          held_d  = o_data;
          held_am = o_am;
        end else begin
          chk("hold_data", o_data, held_d);
          chk("hold_am", W'(o_am), W'(held_am));
        end
        if (!i_ready) chk("bp_o_ready", W'(o_ready), W'(0));
        else begin
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          shown = 0;
        end
      end else if (shown) begin
        checks++;
        errors++;
        $display("FAIL dropped_beat act=o_valid=0 exp=held beat still valid");
        shown = 0;
      end
      if (o_ready && i_valid) begin
        exp_q.push_back('{am: 1'b0, data: i_data, cyc: cyc});
        per_q.push_back(i_data);
        m_cnt++;
        if (m_cnt == AP) begin
          exp_q.push_back('{am: 1'b1, data: am_word(), cyc: -1});
          per_q.delete();
          m_cnt = 0;
        end
      end
    end
  end

  task automatic drive(input bit v, input bit r, input int dm);
    @(posedge clk);
    #1;
    i_valid = v;
    i_ready = r;
    case (dm)
      0: for (int k = 0; k < W / 32; k++) i_data[k*32 +: 32] = $urandom();
      1: i_data = '0;
      default: begin
        i_data = '0;
        i_data[63:0] = 64'h0102_0304_0506_0708;
      end
    endcase
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_o_valid"}, W'(o_valid), W'(0));
    chk({tag, "_o_am"}, W'(o_am), W'(0));
    chk({tag, "_o_data"}, o_data, '0);
    chk({tag, "_o_ready"}, W'(o_ready), W'(0));
  endtask

  initial begin
    int lows;
    int budget;

    // Reset behaviour
    rst_n = 1'b0;
    i_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check_outputs_zero("reset");

    // Continuous flow from reset release: exactly one o_ready-low cycle in every 17
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    i_valid = 1'b1;
    lows = 0;
    #3;
    if (!o_ready) lows++;
    for (int i = 1; i < 3 * (AP + 1); i++) begin
      drive(1, 1, 0);
      #3;
      if (!o_ready) lows++;
    end
    chk("ready_low_count", W'(lows), W'(3));

    // Single non-zero lane-0 word amid zero beats, then a clean period
    for (int i = 0; i < 20; i++) drive(1, 1, 1);
    drive(1, 1, 2);
    for (int i = 0; i < 40; i++) drive(1, 1, 1);

    // Backpressure for 5 cycles mid-period
    for (int i = 0; i < 6; i++) drive(1, 1, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0);
    for (int i = 0; i < 30; i++) drive(1, 1, 0);

    // One beat every three cycles
    for (int i = 0; i < 60; i++) drive(i % 3 == 0, 1, 0);

    // Random valid/ready mix
    for (int i = 0; i < 300; i++)
      drive($urandom_range(99) < 70, $urandom_range(99) < 70, 0);

    // Asynchronous reset after 9 data beats of a period
    budget = 0;
    do begin
      drive(1, 1, 0);
      budget++;
    end while (m_cnt != 9 && budget < 60);
    chk("reach_9_beats", W'(m_cnt), W'(9));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) drive(1, 1, 0);

    // Drain remaining expected beats
    budget = 0;
    do begin
      drive(0, 1, 0);
      budget++;
    end while ((exp_q.size() != 0 || o_valid) && budget < 40);
    chk("drain_empty", W'(exp_q.size()), W'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
